// File: rtl/m_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: RV32M op codes,
// FSM state encodings and operand-signedness helpers.
package pkg_muldiv;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // MUL only keeps the low half, which is sign-agnostic, so it runs unsigned.
  function automatic logic op_a_signed(input op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/m_muldiv_if.sv
// Request/result bus of the multiply/divide unit.
interface m_muldiv_if #(
  parameter int XLEN = 32
);
  // Request: accepted on a rising edge when i_valid && o_ready && !i_flush.
  // Result: consumed on a rising edge when o_valid && i_ready; o_result holds
  // steady while o_valid is high.
  logic            i_valid;
  logic            o_ready;
  logic [2:0]      i_op;
  logic [XLEN-1:0] i_a;
  logic [XLEN-1:0] i_b;
  logic            i_flush;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_result;
  logic            o_busy;

  modport slave (
    input  i_valid, i_op, i_a, i_b, i_flush, i_ready,
    output o_ready, o_valid, o_result, o_busy
  );

  modport master (
    output i_valid, i_op, i_a, i_b, i_flush, i_ready,
    input  o_ready, o_valid, o_result, o_busy
  );
endinterface

// File: rtl/m_muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply step or restoring
// shift-subtract divide step over the {hi, lo} register pair.
module m_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            div_mode,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] m,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          ge;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    shifted = {hi, lo[XLEN-1]};
    ge      = (shifted >= {1'b0, m});
    diff    = shifted - {1'b0, m};
    if (div_mode) begin
      // Partial remainder stays below the divisor, so XLEN bits always suffice.
      hi_next = XLEN'(ge ? diff : shifted);
      lo_next = {lo[XLEN-2:0], ge};
    end else begin
      hi_next = sum[XLEN:1];
      lo_next = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/m_muldiv.sv
// Multi-cycle RV32M multiply/divide unit: one bit per cycle through
// m_muldiv_step, then a sign fix-up cycle; divide special cases may finish early.
module m_muldiv
  import pkg_muldiv::*;
#(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  m_muldiv_if.slave   bus,
  output state_e      o_dbg_state
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  op_e             op_q;
  logic            div_q, spec_q, neg_lo_q, neg_hi_q;
  logic [XLEN-1:0] hi_q, lo_q, m_q, spec_res_q, result_q;
  logic [XLEN-1:0] hi_nx, lo_nx;

  op_e             op_in;
  logic            a_neg, b_neg, is_div, div_zero, ovf, special, accept;
  logic [XLEN-1:0] mag_a, mag_b, spec_res, fix_res;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] quo, rem;

  // Request decode: magnitudes and special-case results come straight off the bus.
  always_comb begin
    op_in    = op_e'(bus.i_op);
    is_div   = bus.i_op[2];
    a_neg    = op_a_signed(op_in) & bus.i_a[XLEN-1];
    b_neg    = op_b_signed(op_in) & bus.i_b[XLEN-1];
    mag_a    = a_neg ? -bus.i_a : bus.i_a;
    mag_b    = b_neg ? -bus.i_b : bus.i_b;
    div_zero = is_div && (bus.i_b == '0);
    ovf      = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
               (bus.i_a == MOST_NEG) && (bus.i_b == '1);
    special  = div_zero || ovf;
    spec_res = '0;
    if (div_zero)  spec_res = bus.i_op[1] ? bus.i_a : '1;
    else if (ovf)  spec_res = bus.i_op[1] ? '0 : bus.i_a;
    accept   = (state_q == ST_IDLE) && bus.i_valid && !bus.i_flush;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (EARLY_OUT && special) ? ST_DONE : ST_CALC;
      ST_CALC: if (bus.i_flush) state_d = ST_IDLE;
               else if (cnt_q == '0) state_d = ST_FIX;
      ST_FIX:  state_d = bus.i_flush ? ST_IDLE : ST_DONE;
      ST_DONE: if (bus.i_flush || bus.i_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  m_muldiv_step #(.XLEN(XLEN)) u_step (
    .div_mode (div_q),
    .hi       (hi_q),
    .lo       (lo_q),
    .m        (m_q),
    .hi_next  (hi_nx),
    .lo_next  (lo_nx)
  );

  // Sign fix-up: product/quotient take the xor of operand signs, remainder the dividend's.
  always_comb begin
    prod    = {hi_q, lo_q};
    prod_s  = neg_lo_q ? -prod : prod;
    quo     = neg_lo_q ? -lo_q : lo_q;
    rem     = neg_hi_q ? -hi_q : hi_q;
    fix_res = '0;
    case (op_q)
      OP_MUL:                       fix_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = quo;
      OP_REM, OP_REMU:              fix_res = rem;
      default:                      fix_res = '0;
    endcase
    if (spec_q) fix_res = spec_res_q;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q      <= '0;
      op_q       <= OP_MUL;
      div_q      <= 1'b0;
      spec_q     <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      m_q        <= '0;
      spec_res_q <= '0;
      result_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          op_q       <= op_in;
          div_q      <= is_div;
          spec_q     <= special;
          spec_res_q <= spec_res;
          neg_lo_q   <= a_neg ^ b_neg;
          neg_hi_q   <= a_neg;
          cnt_q      <= CW'(XLEN-1);
          hi_q       <= '0;
          lo_q       <= is_div ? mag_a : mag_b;
          m_q        <= is_div ? mag_b : mag_a;
          if (EARLY_OUT && special) result_q <= spec_res;
        end
        ST_CALC: begin
          hi_q <= hi_nx;
          lo_q <= lo_nx;
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        end
        ST_FIX:  result_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign bus.o_ready    = (state_q == ST_IDLE);
  assign bus.o_busy     = (state_q != ST_IDLE);
  assign bus.o_valid    = (state_q == ST_DONE);
  assign bus.o_result   = result_q;
  assign o_dbg_state    = state_q;

endmodule

// File: doc/m_muldiv.md
M_MULDIV -- requirements
Module: m_muldiv

Interface
REQ-001 Parameter XLEN, default 32: operand/result width, SHALL accept any even value 8..64.
REQ-002 Parameter EARLY_OUT, default 1: 1 enables one-cycle completion of special-case divides.
REQ-003 i_clk  input  1  sole clock, all state on rising edge.
REQ-004 i_reset_n  input  1  asynchronous, active-low reset.
REQ-005 i_valid  input  1  request present.
REQ-006 o_ready  output  1  unit idle, request accepted this edge if i_valid.
REQ-007 i_op  input  3  operation: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (RV32M funct3 order 0..7).
REQ-008 i_a, i_b  input  XLEN  rs1, rs2 operands.
REQ-009 i_flush  input  1  synchronous abort of the operation in flight.
REQ-010 o_valid  output  1  result present.
REQ-011 i_ready  input  1  consumer takes result this edge if o_valid.
REQ-012 o_result  output  XLEN  result, stable while o_valid high.
REQ-013 o_busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, CALC, FIX, DONE; o_ready SHALL equal (state == IDLE).
REQ-015 IDLE -> CALC on i_valid; operands, op and signs SHALL be latched, magnitudes formed per op signedness (MULHSU: a signed, b unsigned).
REQ-016 CALC SHALL run exactly XLEN cycles, one bit per cycle: shift-add for multiplies (2*XLEN-bit product), restoring shift-subtract for divides; iteration counter counts XLEN-1 down to 0.
REQ-017 CALC -> FIX when counter is 0; FIX applies sign correction (negate product/quotient/remainder as required, remainder takes dividend sign) and selects low/high half, then -> DONE.
REQ-018 Latency: o_valid SHALL rise XLEN+2 edges after the accepting edge for normal operations.
REQ-019 Divide by zero: quotient SHALL be all ones, remainder SHALL be i_a, both signed and unsigned.
REQ-020 Signed overflow (DIV/REM with a = most-negative, b = -1): quotient SHALL be a, remainder 0.
REQ-021 With EARLY_OUT=1, REQ-019/020 cases SHALL go IDLE -> DONE, o_valid one edge after accept; with EARLY_OUT=0 they take normal latency with identical results.
REQ-022 DONE holds o_valid and o_result until i_valid&&... no: until i_ready sampled high, then -> IDLE; new request cannot be accepted on the same edge (one IDLE cycle minimum between results).
REQ-023 i_flush high in CALC, FIX or DONE SHALL return to IDLE next edge with o_valid low; i_flush in IDLE has no effect and blocks acceptance that edge.
REQ-024 Input changes while not IDLE SHALL not affect the operation in flight.
REQ-025 All arithmetic SHALL be modulo 2^XLEN on outputs; no X on o_result for any defined i_op.

Reset
REQ-026 i_reset_n low SHALL immediately force state IDLE, o_valid 0, o_busy 0, o_result 0, counter 0, datapath registers 0; o_ready 1.
REQ-027 Reset asserted mid-operation SHALL discard it; no result is ever produced for it.
REQ-028 Release SHALL be synchronised to i_clk by the instantiating level; first request accepted on the first edge after release.

Structure
REQ-029 Shared package pkg_muldiv SHALL hold op encodings and FSM state encodings; XLEN stays a module parameter.
REQ-030 One sub-module m_muldiv_step (combinational one-bit shift-add / shift-subtract step) SHALL be instantiated; FSM, counter and sign fix-up remain in m_muldiv.
REQ-031 Block is a drop-in multi-cycle replacement for combinational div/rem in the processor; core stalls PC while o_busy.

Verification (XLEN=32, EARLY_OUT=1)
REQ-032 MUL a=7, b=0xFFFFFFFD -> o_result 0xFFFFFFEB, o_valid exactly 34 edges after accept.
REQ-033 MULH a=b=0x80000000 -> 0x40000000; MULHU same -> 0x40000000; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
REQ-034 DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU same -> 0x7FFFFFFC.
REQ-035 DIVU a=0x1234, b=0 -> 0xFFFFFFFF one edge after accept; REM a=0x1234, b=0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-036 i_ready held low 10 cycles in DONE -> o_valid and o_result stable throughout; i_flush at CALC cycle 5 -> o_valid never rises, o_ready high next edge.
REQ-037 i_reset_n pulsed low mid-CALC (between edges) -> outputs zero immediately, o_ready 1; following MUL 3*5 returns 15 with normal latency.
